is_palindrome: RTL and testbench
================================

// Module: is_palindrome
// PURPOSE
//  Decides whether a 32-bit unsigned input is a palindrome in DECIMAL digits (181 -> yes, 180 -> no).
//  Started by a level go_i; iteratively divides by 10, rebuilds the digit-reversed value, compares it with the original.
//  Exposes its FSM state so the enclosing controller/bench can detect completion (states 6/9).
// PARAMETERS
//  W        32  input operand width
//  REV_W    34  reversed-value register width (10 digits max, 10^10 < 2^34, never overflows)
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  go_i        in   1   start request, level-sensitive
//  number      in   32  unsigned operand, sampled once in LOAD
//  result      out  1   1 = palindrome; valid in done states
//  stuckState  out  4   current FSM state code (see encoding)
//  Port order at instantiation: result, stuckState, clk, reset, go_i, number.
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE(0), result=0, all datapath regs 0; a reset mid-operation aborts instantly.
//  Registers: orig[31:0], n[31:0], rev[33:0]; result registered.
//  State encoding / transitions (stuckState = state code, registered):
//   0 IDLE      : result=0; go_i==1 -> LOAD, else stay
//   1 LOAD      : orig<=number, n<=number, rev<=0 -> TEST
//   2 TEST      : n==0 -> COMPARE(7), else DIV_START(3)
//   3 DIV_START : one-cycle start pulse to divider with dividend n -> DIV_WAIT
//   4 DIV_WAIT  : wait for divider done -> ACCUM
//   5 ACCUM     : rev<=rev*10+rem (zero-extended), n<=quot -> TEST
//   7 COMPARE   : rev=={2'b0,orig} -> DONE_PAL(6), else DONE_NOT(9)
//   6 DONE_PAL  : result=1; stay while go_i==1; go_i==0 -> IDLE (result cleared)
//   9 DONE_NOT  : result=0; stay while go_i==1; go_i==0 -> IDLE
//   8,10-15     : illegal -> IDLE next cycle, result=0
//  number==0 -> palindrome (TEST sees n==0 at once, rev==orig==0).
//  Single digit (1..9) -> palindrome. Trailing zeros (10, 180) -> not palindrome.
//  number changes after LOAD are ignored; go_i dropping mid-computation is ignored (run completes, then IDLE).
//  result only changes on entry to/exit from done states; it is 0 in all non-done states.
//  Latency: IDLE->LOAD 1, LOAD->TEST 1, per decimal digit 3+DIV_CYC cycles, TEST->COMPARE->done 2.
//   With DIV_CYC=32: 181 reaches state 6 in 1+1+3*35+2 = 109 cycles after go_i sampled.
// STRUCTURE
//  Shared package (palindrome_pkg): state localparams (S_IDLE=0..S_DONE_NOT=9), W, REV_W, DIV_CYC=32.
//  One sub-module: div10 -- sequential restoring divide-by-10:
//   ports clk, reset(async low), start, dividend[31:0], quot[31:0], rem[3:0], done (1-cycle pulse);
//   done asserted exactly DIV_CYC=32 cycles after start; start while busy ignored; reset clears to idle.
//  rev*10 implemented as (rev<<3)+(rev<<1); compare zero-extends orig to REV_W.
// TESTING
//  number=181 (0xB5), go_i=1 -> stuckState reaches 6, result=1; go_i=0 -> state 0, result=0.
//  number=180 -> state 9, result=0; number=10 -> state 9, result=0.
//  number=0 -> state 6 after 4 cycles (IDLE,LOAD,TEST,COMPARE), result=1; number=7 -> state 6, result=1.
//  number=1234554321 -> 6/result=1; number=4294967295 -> 9/result=0 (rev=5927694924, no overflow).
//  Assert reset=0 while in DIV_WAIT -> state 0, result 0 immediately; release with go_i=1 -> fresh correct run.
//  Hold go_i=1 in done state for 10 cycles -> state and result stable; toggle number meanwhile -> no effect.

Source files
------------

// File: rtl/palindrome_pkg.sv
// Shared constants and state encoding for the decimal palindrome checker.
package palindrome_pkg;

  localparam int W       = 32;
  localparam int REV_W   = 34;
  localparam int DIV_CYC = 32;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_TEST      = 4'd2,
    S_DIV_START = 4'd3,
    S_DIV_WAIT  = 4'd4,
    S_ACCUM     = 4'd5,
    S_DONE_PAL  = 4'd6,
    S_COMPARE   = 4'd7,
    S_DONE_NOT  = 4'd9
  } state_t;

endpackage

// File: rtl/is_palindrome_div10.sv
// Sequential restoring divider by ten: one quotient bit per cycle,
// the first bit is resolved in the same cycle the start is accepted.
module div10
  import palindrome_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  output logic [W-1:0] quot,
  output logic [3:0]   rem,
  output logic         done
);

  logic [W-1:0] q;
  logic [3:0]   r;
  logic [5:0]   cnt;
  logic         busy;
  logic         load;
  logic [W-1:0] q_src;
  logic [3:0]   r_src;
  logic [4:0]   trial;
  logic [3:0]   r_next;
  logic         q_bit;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract ten when it fits.
  always_comb begin
    load   = start && !busy;
    q_src  = load ? dividend : q;
    r_src  = load ? 4'd0 : r;
    trial  = {r_src, q_src[W-1]};
    q_bit  = 1'b0;
    r_next = trial[3:0];
    if (trial >= 5'd10) begin
      q_bit  = 1'b1;
      r_next = 4'(trial - 5'd10);
    end
  end

  // Iteration register; results stay stable after done until the next start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      r    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load || busy) begin
        q <= {q_src[W-2:0], q_bit};
        r <= r_next;
      end
      if (load) begin
        busy <= 1'b1;
        cnt  <= 6'd1;
      end else if (busy) begin
        if (cnt == 6'(DIV_CYC - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 6'd1;
        end
      end
    end
  end

  assign quot = q;
  assign rem  = r;

endmodule

// File: rtl/is_palindrome.sv
// Decimal palindrome checker: peels digits off with a divide-by-ten,
// rebuilds the digit-reversed value and compares it with the original.
module is_palindrome
  import palindrome_pkg::*;
(
  output logic         result,
  output logic [3:0]   stuckState,
  input  logic         clk,
  input  logic         reset,
  input  logic         go_i,
  input  logic [W-1:0] number
);

  state_t           state, next_state;
  logic [W-1:0]     orig, n;
  logic [REV_W-1:0] rev, rev_next;
  logic             load_en, accum_en, div_start;
  logic             div_done;
  logic [W-1:0]     div_quot;
  logic [3:0]       div_rem;

  div10 u_div10 (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (n),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  // rev*10 as two shifts plus the new digit; 34 bits hold any 10-digit reversal.
  always_comb begin
    rev_next = (rev << 3) + (rev << 1) + {{(REV_W-4){1'b0}}, div_rem};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and datapath control decode.
  always_comb begin
    next_state = state;
    load_en    = 1'b0;
    accum_en   = 1'b0;
    div_start  = 1'b0;
    case (state)
      S_IDLE:      if (go_i) next_state = S_LOAD;
      S_LOAD: begin
        load_en    = 1'b1;
        next_state = S_TEST;
      end
      S_TEST:      next_state = (n == '0) ? S_COMPARE : S_DIV_START;
      S_DIV_START: begin
        div_start  = 1'b1;
        next_state = S_DIV_WAIT;
      end
      S_DIV_WAIT:  if (div_done) next_state = S_ACCUM;
      S_ACCUM: begin
        accum_en   = 1'b1;
        next_state = S_TEST;
      end
      S_COMPARE:   next_state = (rev == {2'b00, orig}) ? S_DONE_PAL : S_DONE_NOT;
      S_DONE_PAL:  if (!go_i) next_state = S_IDLE;
      S_DONE_NOT:  if (!go_i) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Operand capture, digit accumulation, and the registered verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      orig   <= '0;
      n      <= '0;
      rev    <= '0;
      result <= 1'b0;
    end else begin
      if (load_en) begin
        orig <= number;
        n    <= number;
        rev  <= '0;
      end else if (accum_en) begin
        rev <= rev_next;
        n   <= div_quot;
      end
      result <= (next_state == S_DONE_PAL);
    end
  end

  assign stuckState = state;

endmodule

// File: tb/tb_is_palindrome.sv
// Scoreboard bench for is_palindrome: stimulus pushes expected verdicts,
// a monitor pops and compares each time the FSM enters a done state.
module tb_is_palindrome;
  import palindrome_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        go_i;
  logic [31:0] number;
  logic        result;
  logic [3:0]  stuckState;

  typedef struct {
    logic [31:0] num;
    logic [3:0]  st;
    logic        res;
    int          lat;
    int          start_edge;
  } exp_t;

  typedef struct {
    logic [31:0] num;
    logic [3:0]  st;
    logic        res;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   edge_count = 0;
  int   n_checks   = 0;
  int   n_pass     = 0;
  logic prev_done  = 1'b0;

  is_palindrome dut (
    .result     (result),
    .stuckState (stuckState),
    .clk        (clk),
    .reset      (reset),
    .go_i       (go_i),
    .number     (number)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Count rising edges so latency can be measured from go_i being sampled.
  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: on each entry into a done state pop one expectation and compare.
  always @(negedge clk) begin
    logic now_done;
    exp_t e;
    now_done = (stuckState == 4'd6) || (stuckState == 4'd9);
    if (reset === 1'b1 && now_done && !prev_done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("state_%0d", e.num), stuckState, e.st);
        checkOutput($sformatf("result_%0d", e.num), result, e.res);
        checkOutput($sformatf("latency_%0d", e.num), edge_count - e.start_edge, e.lat);
      end
    end
    prev_done = (reset === 1'b1) && now_done;
  end

  // Start one run, wait for completion, hold go_i while toggling number, release.
  task automatic applyStimulus(input vec_t v, input int hold);
    exp_t e;
    bit   seen;
    number = v.num;
    go_i   = 1'b1;
    e.num = v.num; e.st = v.st; e.res = v.res; e.lat = v.lat; e.start_edge = edge_count;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (stuckState == 4'd6 || stuckState == 4'd9) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checkOutput($sformatf("timeout_%0d", v.num), 0, 1);
      void'(sb.pop_front());
    end
    for (int i = 0; i < hold; i++) begin
      number = number ^ 32'h0000_0101;
      @(posedge clk); #1;
      checkOutput($sformatf("hold_state_%0d", v.num), stuckState, v.st);
      checkOutput($sformatf("hold_result_%0d", v.num), result, v.res);
    end
    go_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("back_to_idle_state", stuckState, 0);
    checkOutput("back_to_idle_result", result, 0);
  endtask

  vec_t vecs[9] = '{
    '{32'd181,        4'd6, 1'b1, 109},
    '{32'd180,        4'd9, 1'b0, 109},
    '{32'd10,         4'd9, 1'b0,  74},
    '{32'd0,          4'd6, 1'b1,   4},
    '{32'd7,          4'd6, 1'b1,  39},
    '{32'd12321,      4'd6, 1'b1, 179},
    '{32'd1234554321, 4'd6, 1'b1, 354},
    '{32'd4294967295, 4'd9, 1'b0, 354},
    '{32'd1000000001, 4'd6, 1'b1, 354}
  };

  // Main stimulus sequence.
  initial begin
    bit   reached;
    vec_t again;
    reset  = 1'b0;
    go_i   = 1'b0;
    number = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", stuckState, 0);
    checkOutput("reset_result", result, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) applyStimulus(vecs[i], (i < 2) ? 10 : 2);

    // Abort a run while the divider is busy, then start a fresh one.
    number  = 32'd181;
    go_i    = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (stuckState == 4'd4) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("reach_div_wait", reached, 1);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_state", stuckState, 0);
    checkOutput("abort_result", result, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    again = '{32'd181, 4'd6, 1'b1, 109};
    applyStimulus(again, 2);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Last-resort guard so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
